// File: rtl/ir_nec_decoder.sv
// ir_nec_decoder
//   Decodes the demodulated, active-low output of an NEC infrared receiver
//   into a 32-bit code. Pulse widths are measured in ticks of TICK_DIV
//   system clocks (10 us at 50 MHz with the default).
//
// Parameters
//   TICK_DIV     system clocks per width-measurement tick
//   CHECK_INV    1: accept a frame only if both inverse bytes match
//
// Ports
//   clk          system clock
//   res          asynchronous active-low reset
//   ir           raw receiver output (low = burst, idle high), async to clk
//   code         last accepted frame, first received bit in code[0]
//                (addr=[7:0], ~addr=[15:8], cmd=[23:16], ~cmd=[31:24])
//   data_valid   one-cycle pulse, code updated in the same cycle
//   repeat_pulse one-cycle pulse on a valid repeat frame
//   err          one-cycle pulse on a protocol or inverse-check failure
//                after a valid leader low
module ir_nec_decoder #(
    parameter int TICK_DIV  = 500,
    parameter bit CHECK_INV = 1'b1
) (
    input  logic        clk,
    input  logic        res,
    input  logic        ir,
    output logic [31:0] code,
    output logic        data_valid,
    output logic        repeat_pulse,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD_LOW,
        LEAD_HIGH,
        BIT_LOW,
        BIT_HIGH,
        FINISH,
        RPT_LOW
    } state_t;

    localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [10:0]   CNT_SAT   = 11'd2047;

    // Acceptance windows in ticks, bounds inclusive.
    localparam logic [10:0] LL_MIN = 11'd800, LL_MAX = 11'd1000;
    localparam logic [10:0] LH_MIN = 11'd400, LH_MAX = 11'd500;
    localparam logic [10:0] RH_MIN = 11'd180, RH_MAX = 11'd270;
    localparam logic [10:0] BL_MIN = 11'd35,  BL_MAX = 11'd80;
    localparam logic [10:0] S0_MIN = 11'd35,  S0_MAX = 11'd80;
    localparam logic [10:0] S1_MIN = 11'd130, S1_MAX = 11'd210;

    function automatic logic in_win(input logic [10:0] v,
                                    input logic [10:0] lo,
                                    input logic [10:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // ------------------------------------------------------------------
    // Input synchronizer and edge detection
    // ------------------------------------------------------------------
    logic ir_meta, irs, irs_d;

    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, like real hardware.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            ir_meta <= 1'b1;
            irs     <= 1'b1;
            irs_d   <= 1'b1;
        end else begin
            ir_meta <= ir;
            irs     <= ir_meta;
            irs_d   <= irs;
        end
    end

    logic fall, rise, edge_seen;
    assign fall      = irs_d & ~irs;
    assign rise      = ~irs_d & irs;
    assign edge_seen = irs_d ^ irs;

    // ------------------------------------------------------------------
    // Tick prescaler and width counter; both restart on every edge so cnt
    // is the width of the current level in whole ticks.
    // ------------------------------------------------------------------
    logic [PW-1:0] presc;
    logic [10:0]   cnt;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            presc <= '0;
            cnt   <= '0;
        end else if (edge_seen) begin
            presc <= '0;
            cnt   <= '0;
        end else if (presc == PRESC_MAX) begin
            presc <= '0;
            if (cnt != CNT_SAT) cnt <= cnt + 11'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t      state, state_nxt;
    logic [5:0]  bitcnt, bitcnt_nxt;
    logic [31:0] shreg, shreg_nxt;
    logic [31:0] code_nxt;
    logic        dv_nxt, rpt_nxt, err_nxt;
    logic        inv_ok;

    assign inv_ok = (shreg[15:8] == ~shreg[7:0]) && (shreg[31:24] == ~shreg[23:16]);

    // NOTE: the shift register is plain flops, not a memory, so it is
    // reset with everything else and never exposes stale bits.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state        <= IDLE;
            bitcnt       <= '0;
            shreg        <= '0;
            code         <= '0;
            data_valid   <= 1'b0;
            repeat_pulse <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_nxt;
            bitcnt       <= bitcnt_nxt;
            shreg        <= shreg_nxt;
            code         <= code_nxt;
            data_valid   <= dv_nxt;
            repeat_pulse <= rpt_nxt;
            err          <= err_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // branch can leave one unassigned and infer a latch.
        state_nxt  = state;
        bitcnt_nxt = bitcnt;
        shreg_nxt  = shreg;
        code_nxt   = code;
        dv_nxt     = 1'b0;
        rpt_nxt    = 1'b0;
        err_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (fall) state_nxt = LEAD_LOW;
            end

            // A bad leader low is treated as noise: no err.
            LEAD_LOW: begin
                if (rise) begin
                    state_nxt = in_win(cnt, LL_MIN, LL_MAX) ? LEAD_HIGH : IDLE;
                end else if (cnt > LL_MAX) begin
                    state_nxt = IDLE;
                end
            end

            LEAD_HIGH: begin
                if (fall) begin
                    if (in_win(cnt, LH_MIN, LH_MAX)) begin
                        state_nxt  = BIT_LOW;
                        bitcnt_nxt = '0;
                    end else if (in_win(cnt, RH_MIN, RH_MAX)) begin
                        state_nxt = RPT_LOW;
                    end else begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                    end
                end else if (cnt > LH_MAX) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end

            // The 33rd burst is the stop burst that closes the frame.
            BIT_LOW: begin
                if (rise) begin
                    if (in_win(cnt, BL_MIN, BL_MAX)) begin
                        state_nxt = (bitcnt == 6'd32) ? FINISH : BIT_HIGH;
                    end else begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                    end
                end else if (cnt > BL_MAX) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end

            // LSB arrives first: shift in at the top, shift right.
            BIT_HIGH: begin
                if (fall) begin
                    if (in_win(cnt, S0_MIN, S0_MAX) || in_win(cnt, S1_MIN, S1_MAX)) begin
                        shreg_nxt  = {in_win(cnt, S1_MIN, S1_MAX), shreg[31:1]};
                        bitcnt_nxt = bitcnt + 6'd1;
                        state_nxt  = BIT_LOW;
                    end else begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                    end
                end else if (cnt > S1_MAX) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end

            // Single-cycle verdict; edges arriving now are deliberately dropped.
            FINISH: begin
                state_nxt = IDLE;
                if (!CHECK_INV || inv_ok) begin
                    code_nxt = shreg;
                    dv_nxt   = 1'b1;
                end else begin
                    err_nxt = 1'b1;
                end
            end

            RPT_LOW: begin
                if (rise) begin
                    state_nxt = IDLE;
                    if (in_win(cnt, BL_MIN, BL_MAX)) rpt_nxt = 1'b1;
                    else                             err_nxt = 1'b1;
                end else if (cnt > BL_MAX) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ir_nec_decoder.sv
// tb_ir_nec_decoder
//   Drives two decoders (inverse check on and off) from one ir line with
//   NEC frames whose widths are drawn at random inside the acceptance
//   windows. A frame-level model predicts the pulse each frame must
//   produce; a per-cycle compare process matches every pulse and the code
//   output against it, and literal codes pin the model at key points.
module tb_ir_nec_decoder;

    localparam int TD        = 2;    // clocks per tick
    localparam int GAP       = 260;  // idle ticks after a frame
    localparam int LONG_HIGH = 300;  // beyond every high-level timeout

    logic        clk = 1'b0;
    logic        res;
    logic        ir;
    logic [31:0] code_inv, code_raw;
    logic        dv_inv, rp_inv, er_inv;
    logic        dv_raw, rp_raw, er_raw;

    ir_nec_decoder #(.TICK_DIV(TD), .CHECK_INV(1'b1)) dut_inv (
        .clk          (clk),
        .res          (res),
        .ir           (ir),
        .code         (code_inv),
        .data_valid   (dv_inv),
        .repeat_pulse (rp_inv),
        .err          (er_inv)
    );

    ir_nec_decoder #(.TICK_DIV(TD), .CHECK_INV(1'b0)) dut_raw (
        .clk          (clk),
        .res          (res),
        .ir           (ir),
        .code         (code_raw),
        .data_valid   (dv_raw),
        .repeat_pulse (rp_raw),
        .err          (er_raw)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_NONE = 0, EV_DV = 1, EV_RPT = 2, EV_ERR = 3} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [31:0] code;
    } ev_t;

    ev_t         q_inv[$];
    ev_t         q_raw[$];
    logic [31:0] mcode [2];
    bit          prev_pulse [2];
    bit          run;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_code(input logic [7:0] addr, input logic [7:0] cmd);
        return {~cmd, cmd, ~addr, addr};
    endfunction

    function automatic bit inv_ok(input logic [31:0] c);
        return (c[15:8] == ~c[7:0]) && (c[31:24] == ~c[23:16]);
    endfunction

    // ------------------------------------------------------------------
    // Model expectations
    // ------------------------------------------------------------------
    function automatic void expect_frame(input logic [31:0] d);
        ev_t e;
        e.code = d;
        e.kind = EV_DV;
        q_raw.push_back(e);
        e.kind = inv_ok(d) ? EV_DV : EV_ERR;
        q_inv.push_back(e);
    endfunction

    function automatic void expect_both(input ev_kind_t k);
        ev_t e;
        e.code = '0;
        e.kind = k;
        q_raw.push_back(e);
        q_inv.push_back(e);
    endfunction

    task automatic end_check(input string name);
        check({name, "_missing_inv"}, q_inv.size(), 0);
        check({name, "_missing_raw"}, q_raw.size(), 0);
        q_inv.delete();
        q_raw.delete();
    endtask

    // ------------------------------------------------------------------
    // Compare process
    // ------------------------------------------------------------------
    task automatic check_dut(input int id, input logic dv, input logic rp,
                             input logic er, input logic [31:0] c);
        int  n;
        int  kind;
        ev_t e;
        bit  have;
        n    = int'(dv) + int'(rp) + int'(er);
        kind = dv ? int'(EV_DV) : rp ? int'(EV_RPT) : er ? int'(EV_ERR) : int'(EV_NONE);
        if (n != 0) begin
            check($sformatf("exclusive_dut%0d", id), n, 1);
            check($sformatf("pulse_width_dut%0d", id), 32'(prev_pulse[id]), 0);
            have = 1'b0;
            if (id == 1 && q_inv.size() > 0) begin e = q_inv.pop_front(); have = 1'b1; end
            if (id == 0 && q_raw.size() > 0) begin e = q_raw.pop_front(); have = 1'b1; end
            if (!have) begin
                check($sformatf("unexpected_pulse_dut%0d", id), kind, int'(EV_NONE));
            end else begin
                check($sformatf("pulse_kind_dut%0d", id), kind, int'(e.kind));
                if (e.kind == EV_DV) mcode[id] = e.code;
            end
        end
        prev_pulse[id] = (n != 0);
        check($sformatf("code_dut%0d", id), c, mcode[id]);
    endtask

    always @(negedge clk) begin
        if (run) begin
            check_dut(1, dv_inv, rp_inv, er_inv, code_inv);
            check_dut(0, dv_raw, rp_raw, er_raw, code_raw);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic seg(input logic lvl, input int ticks);
        ir = lvl;
        repeat (ticks * TD) @(posedge clk);
        #2;
    endtask

    function automatic int wid(input bit nom, input int nominal_w, input int lo, input int hi);
        return nom ? nominal_w : int'($urandom_range(hi, lo));
    endfunction

    task automatic send_leader(input bit nom);
        seg(1'b0, wid(nom, 900, 802, 815));
        seg(1'b1, wid(nom, 450, 402, 415));
    endtask

    task automatic send_bits(input logic [31:0] d, input int n, input bit nom);
        for (int i = 0; i < n; i++) begin
            seg(1'b0, wid(nom, 56, 37, 42));
            seg(1'b1, d[i] ? wid(nom, 169, 132, 140) : wid(nom, 56, 37, 42));
        end
    endtask

    task automatic send_frame(input logic [31:0] d, input bit nom);
        send_leader(nom);
        send_bits(d, 32, nom);
        seg(1'b0, wid(nom, 56, 37, 42));
        seg(1'b1, GAP);
    endtask

    logic [31:0] d;

    initial begin
        res           = 1'b0;
        ir            = 1'b1;
        run           = 1'b0;
        mcode[0]      = '0;
        mcode[1]      = '0;
        prev_pulse[0] = 1'b0;
        prev_pulse[1] = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        run = 1'b1;
        @(negedge clk);
        #1;
        check("rst_code", code_inv, 32'h0);
        check("rst_pulses", {29'd0, dv_inv, rp_inv, er_inv}, 32'h0);
        @(posedge clk);
        #2;
        res = 1'b1;
        seg(1'b1, 20);

        // Nominal-timing frame, addr 0x00 / cmd 0x45.
        d = mk_code(8'h00, 8'h45);
        expect_frame(d);
        send_frame(d, 1'b1);
        end_check("frame_nominal");
        check("frame_nominal_code_inv", code_inv, 32'hBA45FF00);
        check("frame_nominal_code_raw", code_raw, 32'hBA45FF00);

        // Repeat frame: code must hold.
        expect_both(EV_RPT);
        seg(1'b0, wid(1'b0, 0, 802, 815));
        seg(1'b1, wid(1'b0, 0, 182, 195));
        seg(1'b0, wid(1'b0, 0, 37, 42));
        seg(1'b1, GAP);
        end_check("repeat");
        check("repeat_code_hold", code_inv, 32'hBA45FF00);

        // Broken inverse command byte.
        d = {8'hBB, 8'h45, 8'hFF, 8'h00};
        expect_frame(d);
        send_frame(d, 1'b0);
        end_check("bad_inverse");
        check("bad_inverse_code_inv", code_inv, 32'hBA45FF00);
        check("bad_inverse_code_raw", code_raw, 32'hBB45FF00);

        // Leader plus 20 random bits, then a long high: space timeout.
        d = $urandom();
        expect_both(EV_ERR);
        send_leader(1'b0);
        send_bits(d, 20, 1'b0);
        seg(1'b0, wid(1'b0, 0, 37, 42));
        seg(1'b1, LONG_HIGH);
        end_check("partial_timeout");
        check("partial_timeout_code", code_inv, 32'hBA45FF00);

        // 7 ms leader low is noise: no pulse at all.
        seg(1'b0, 700);
        seg(1'b1, GAP);
        end_check("short_leader");

        // Valid frame addr 0x12 / cmd 0x34.
        d = mk_code(8'h12, 8'h34);
        expect_frame(d);
        send_frame(d, 1'b0);
        end_check("frame_12_34");
        check("frame_12_34_code", code_inv, 32'hCB34ED12);

        // Reset after 16 bits of a frame.
        d = $urandom();
        send_leader(1'b0);
        send_bits(d, 16, 1'b0);
        seg(1'b0, wid(1'b0, 0, 37, 42));
        seg(1'b1, 50);
        res = 1'b0;
        q_inv.delete();
        q_raw.delete();
        mcode[0]      = '0;
        mcode[1]      = '0;
        prev_pulse[0] = 1'b0;
        prev_pulse[1] = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("mid_reset_code", code_raw, 32'h0);
        check("mid_reset_pulses", {29'd0, dv_raw, rp_raw, er_raw}, 32'h0);
        @(posedge clk);
        #2;
        res = 1'b1;
        seg(1'b1, GAP);
        end_check("mid_reset");

        // Frame after reset, addr 0x00 / cmd 0x16.
        d = mk_code(8'h00, 8'h16);
        expect_frame(d);
        send_frame(d, 1'b0);
        end_check("after_reset");
        check("after_reset_code_inv", code_inv, 32'hE916FF00);
        check("after_reset_code_raw", code_raw, 32'hE916FF00);

        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ir_nec_decoder.md
Name: ir_nec_decoder

Overview:
Decodes the demodulated, active-low NEC infrared receiver output into a 32-bit code, plus a one-cycle valid strobe. It is the stage directly upstream of the infrared peripheral registers. Its code and data_valid outputs feed the high/low IR registers read by the CPU over the bus. Timing is measured in 10 us ticks derived from the system clock.

Parameters:
TICK_DIV, 500, system clocks per 10 us tick (50 MHz clk).
CHECK_INV, 1, when 1 a frame is accepted only if code[15:8]==~code[7:0] and code[31:24]==~code[23:16].

Ports:
clk  input  1  system clock
res  input  1  asynchronous active-low reset
ir  input  1  raw receiver output; low = carrier burst, idle high; asynchronous to clk
code  output  32  last accepted frame; first received bit in code[0] (addr=[7:0], ~addr=[15:8], cmd=[23:16], ~cmd=[31:24])
data_valid  output  1  one-cycle pulse; code updated in the same cycle
repeat_pulse  output  1  one-cycle pulse on a valid NEC repeat frame
err  output  1  one-cycle pulse on a protocol or inverse-check failure after a valid leader low

Behaviour:
- Single clock; every flop is reset asynchronously by res=0.
- Reset values: code=0, data_valid=0, repeat_pulse=0, err=0, state=IDLE, sync flops=1, counters=0.
- Synchronization: ir passes through a 2-FF synchronizer into irs. Falling and rising edges are detected on irs against its previous value.
- Prescaler counts 0..TICK_DIV-1 and emits a tick on wrap. On every irs edge, both the prescaler and the 11-bit width counter cnt clear. cnt increments per tick and saturates at 2047.
- Acceptance windows (ticks):
  - leader low 800..1000
  - leader high 400..500
  - repeat high 180..270
  - burst low 35..80
  - space 0: 35..80
  - space 1: 130..210
  - All bounds are inclusive.
- States:
  - IDLE: irs fall -> LEAD_LOW.
  - LEAD_LOW: irs rise with cnt in window -> LEAD_HIGH. Rise out of window, or cnt>1000 while low, -> IDLE with no err (treated as noise).
  - LEAD_HIGH: irs fall with cnt in leader-high window -> BIT_LOW, bitcnt=0. Fall in repeat window -> RPT_LOW. Any other fall, or cnt>500, -> IDLE with err.
  - BIT_LOW: irs rise with cnt in burst window -> if bitcnt==32 go to FINISH, else BIT_HIGH. Bad width, or cnt>80, -> IDLE with err.
  - BIT_HIGH: irs fall with cnt in space-0 window shifts in 0; in space-1 window shifts in 1. Shift into shreg[31] and shift right, bitcnt+1, -> BIT_LOW. Other width, or cnt>210, -> IDLE with err.
  - FINISH (1 cycle): if CHECK_INV=0 or both inverse checks pass, code<=shreg and data_valid=1. Otherwise err=1 and code is unchanged. Then -> IDLE.
  - RPT_LOW: irs rise with cnt in burst window -> repeat_pulse=1, IDLE. Bad width or timeout -> IDLE with err.
- Latency: data_valid rises 1 cycle after the clk edge at which the stop-burst rising edge is seen on irs (3 clk after the raw ir rise, excluding window slack).
- The output pulses are mutually exclusive and never exceed one cycle. code holds between frames and through repeats.
- shreg and bitcnt are internal. A partial frame never changes code.
- Reset mid-frame: immediate return to IDLE with outputs cleared. The next complete frame decodes normally.
- A new falling edge during FINISH is ignored. A frame starting within 1 cycle of the stop burst is not required to decode.

Test Plan:
1. Valid frame, addr 0x00 / cmd 0x45, nominal timing -> exactly one data_valid pulse; code=0xBA45FF00; err=0, repeat_pulse=0.
2. Repeat frame (9 ms low, 2.25 ms high, 562 us burst) 40 ms after case 1 -> one repeat_pulse; code stays 0xBA45FF00; no data_valid.
3. Frame with cmd 0x45 and inverse byte 0xBB, CHECK_INV=1 -> one err pulse at FINISH; code unchanged. Same frame with CHECK_INV=0 -> data_valid, code=0xBB45FF00.
4. Leader low of 7 ms, then idle, then a valid frame addr 0x12 / cmd 0x34 -> first burst gives no pulses; second gives code=0xCB34ED12.
5. Valid leader plus 20 bits, then ir high for 20 ms -> err pulse when cnt exceeds 210; state returns to IDLE; a following valid frame decodes correctly.
6. res pulsed low after 16 bits of a frame -> all outputs 0 during and after reset; the next complete frame (addr 0x00 / cmd 0x16) gives code=0xE916FF00. Run with TICK_DIV=5 for fast simulation, with widths scaled to match.
